// File: rtl/mb20_quad_bank.sv
// MB20-style core memory bank, one MBUS phase: quadword read/write cycles with
// wrapping word offset, pipelined read data, and NXM / parity / timeout reporting.
module mb20_quad_bank #(
  parameter int WIDTH      = 36,
  parameter int ADDR_W     = 22,
  parameter int DEPTH      = 262144,
  parameter int READ_LAT   = 2,
  parameter int WR_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] adr,
  input  logic [3:0]        rq,
  input  logic              wr,
  output logic              ackn,
  output logic              inValid,
  output logic [WIDTH-1:0]  dOut,
  output logic              parOut,
  input  logic              outValid,
  input  logic [WIDTH-1:0]  dIn,
  input  logic              parIn,
  output logic              busy,
  output logic              nxm,
  output logic              parErr,
  output logic              wrTmo
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WR_TIMEOUT + 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(WR_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_DRAIN, S_WR, S_WAIT} state_t;

  state_t              state, state_n;
  logic [ADDR_W-3:0]   base;
  logic [1:0]          wo, wo_n;
  logic [3:0]          pend, pend_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                accept, rd_push, mem_we, take, wstep;
  logic                nxm_q, tail_empty;
  logic [ADDR_W-1:0]   cur_addr;
  logic                word_nx;
  logic [IDX_W-1:0]    idx;
  logic [READ_LAT-1:0] pvld;
  logic [WIDTH-1:0]    pdat [READ_LAT];
  logic [WIDTH-1:0]    mem  [DEPTH];

  assign cur_addr = {base, wo};
  assign word_nx  = {1'b0, cur_addr} >= DEPTH_L;
  assign idx      = cur_addr[IDX_W-1:0];

  // DRAIN may leave once only the last pipeline stage (or nothing) is occupied
  always_comb begin
    tail_empty = 1'b1;
    for (int unsigned i = 0; i < READ_LAT - 1; i++)
      if (pvld[i]) tail_empty = 1'b0;
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    wo_n    = wo;
    cnt_n   = cnt;
    accept  = 1'b0;
    ackn    = 1'b0;
    rd_push = 1'b0;
    mem_we  = 1'b0;
    take    = 1'b0;
    wstep   = 1'b0;
    parErr  = 1'b0;
    wrTmo   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && rq != '0) begin
          accept  = 1'b1;
          state_n = wr ? S_WR : S_RD;
        end
      end
      S_RD: begin
        ackn    = pend[0];
        rd_push = pend[0];
        pend_n  = pend >> 1;
        wo_n    = wo + 2'd1;
        if (pend_n == '0) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (tail_empty) state_n = S_IDLE;
      end
      S_WR: begin
        if (pend[0]) begin
          ackn = 1'b1;
          if (outValid) begin
            take = 1'b1;
          end else begin
            cnt_n   = CNT_W'(1);
            state_n = S_WAIT;
          end
        end else begin
          wstep = 1'b1;
        end
      end
      S_WAIT: begin
        if (outValid) begin
          take = 1'b1;
        end else if (cnt == TMO_LAST) begin
          wrTmo   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (take) begin
      mem_we = 1'b1;
      parErr = parIn ^ (^dIn);
      wstep  = 1'b1;
    end
    if (wstep) begin
      pend_n  = pend >> 1;
      wo_n    = wo + 2'd1;
      state_n = (pend_n == '0) ? S_IDLE : S_WR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      base  <= '0;
      wo    <= '0;
      pend  <= '0;
      cnt   <= '0;
      nxm_q <= 1'b0;
      pvld  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      nxm_q <= accept && ({1'b0, adr} >= DEPTH_L);
      if (accept) begin
        base <= adr[ADDR_W-1:2];
        wo   <= adr[1:0];
        pend <= rq;
      end else begin
        wo   <= wo_n;
        pend <= pend_n;
      end
      pvld[0] <= rd_push;
      for (int unsigned i = 1; i < READ_LAT; i++) pvld[i] <= pvld[i-1];
    end
  end

  // Array and read-data stages carry no reset so memory contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we && !word_nx && !reset) mem[idx] <= dIn;
    if (rd_push) pdat[0] <= word_nx ? '0 : mem[idx];
    for (int unsigned i = 1; i < READ_LAT; i++) pdat[i] <= pdat[i-1];
  end

  assign inValid = pvld[READ_LAT-1];
  assign dOut    = inValid ? pdat[READ_LAT-1] : '0;
  assign parOut  = ^dOut;
  assign busy    = (state != S_IDLE);
  assign nxm     = nxm_q;

endmodule

// File: tb/tb_mb20_quad_bank.sv
// Randomised scoreboard bench for mb20_quad_bank: the driver predicts every
// output event by cycle from a word-level memory model; a monitor compares.
module tb_mb20_quad_bank;
  localparam int WIDTH  = 36;
  localparam int ADDR_W = 22;
  localparam int DEPTH  = 4096;
  localparam int LAT    = 2;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset, start, wr, outValid, parIn;
  logic [ADDR_W-1:0] adr;
  logic [3:0]        rq;
  logic [WIDTH-1:0]  dIn, dOut;
  logic              ackn, inValid, parOut, busy, nxm, parErr, wrTmo;

  mb20_quad_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                   .READ_LAT(LAT), .WR_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .adr(adr), .rq(rq), .wr(wr),
    .ackn(ackn), .inValid(inValid), .dOut(dOut), .parOut(parOut),
    .outValid(outValid), .dIn(dIn), .parIn(parIn), .busy(busy),
    .nxm(nxm), .parErr(parErr), .wrTmo(wrTmo));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [35:0] d; } rd_t;
  rd_t         rd_q[$];
  int          ack_q[$], nxm_q[$], perr_q[$], tmo_q[$];
  int          cur_t = 0, busy_end = -1;
  bit          mon_en = 0, tb_done = 0;
  logic [35:0] ref_mem [int];
  int          checks = 0, errors = 0;

  logic [35:0] w_dat [4];
  int          w_dl  [4];
  logic [3:0]  w_bad;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: every cycle compares all outputs against what the driver scheduled
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        e = (ack_q.size() > 0) && (ack_q[0] == cyc);
        if (e) void'(ack_q.pop_front());
        chk("ackn", 64'(ackn), 64'(e));
        e = (nxm_q.size() > 0) && (nxm_q[0] == cyc);
        if (e) void'(nxm_q.pop_front());
        chk("nxm", 64'(nxm), 64'(e));
        e = (perr_q.size() > 0) && (perr_q[0] == cyc);
        if (e) void'(perr_q.pop_front());
        chk("parErr", 64'(parErr), 64'(e));
        e = (tmo_q.size() > 0) && (tmo_q[0] == cyc);
        if (e) void'(tmo_q.pop_front());
        chk("wrTmo", 64'(wrTmo), 64'(e));
        e = (rd_q.size() > 0) && (rd_q[0].c == cyc);
        chk("inValid", 64'(inValid), 64'(e));
        if (e) begin
          chk("dOut", 64'(dOut), 64'(rd_q[0].d));
          chk("parOut", 64'(parOut), 64'(^rd_q[0].d));
          void'(rd_q.pop_front());
        end else begin
          chk("dOut_idle", 64'(dOut), 64'd0);
          chk("parOut_idle", 64'(parOut), 64'd0);
        end
        chk("busy", 64'(busy), 64'(cyc > cur_t && cyc <= busy_end));
      end
      if (tb_done || cyc > 60000) begin
        if (!tb_done) begin
          errors++;
          $display("FAIL run_timeout cyc=%0d got=unfinished expected=finished", cyc);
        end
        chk("queues_drained",
            64'(rd_q.size() + ack_q.size() + nxm_q.size() + perr_q.size() + tmo_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until_free();
    while (cyc <= busy_end) step();
  endtask

  function automatic logic [35:0] rnd36();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return x[35:0];
  endfunction

  function automatic int word_addr(input int a, input int k);
    return (a & ~3) | ((a + k) & 3);
  endfunction

  // Read: word k of the mask is acked k+1 cycles after issue, data LAT later
  task automatic do_read(input int a, input logic [3:0] r, input bit poke);
    int t, last, w;
    idle_until_free();
    t = cyc;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      if (r[k]) begin
        last = k;
        w = word_addr(a, k);
        ack_q.push_back(t + 1 + k);
        rd_q.push_back('{t + 1 + k + LAT, (w >= DEPTH) ? 36'd0 : ref_mem[w]});
      end
    end
    if (a >= DEPTH) nxm_q.push_back(t + 1);
    cur_t = t;
    busy_end = t + 1 + last + LAT;
    start = 1'b1; adr = ADDR_W'(a); rq = r; wr = 1'b0;
    step();
    start = 1'b0;
    if (poke) begin
      step();
      start = 1'b1; adr = ADDR_W'(a ^ 4); rq = 4'b1111; wr = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  // Write: w_dl[k] = cycles from ack to outValid; >= TMO means never sent
  task automatic do_write(input int a, input logic [3:0] r);
    int t, c, wa;
    int ovc [4];
    bit fin;
    idle_until_free();
    t = cyc;
    c = t + 1;
    fin = 0;
    for (int k = 0; k < 4; k++) ovc[k] = -1;
    if (a >= DEPTH) nxm_q.push_back(t + 1);
    for (int k = 0; k < 4; k++) begin
      if (!fin) begin
        if ((r >> k) == 4'd0) fin = 1;
        else if (!r[k]) c++;
        else begin
          ack_q.push_back(c);
          if (w_dl[k] >= TMO) begin
            tmo_q.push_back(c + TMO - 1);
            c = c + TMO;
            fin = 1;
          end else begin
            ovc[k] = c + w_dl[k];
            if (w_bad[k]) perr_q.push_back(ovc[k]);
            wa = word_addr(a, k);
            if (wa < DEPTH) ref_mem[wa] = w_dat[k];
            c = ovc[k] + 1;
          end
        end
      end
    end
    cur_t = t;
    busy_end = c - 1;
    start = 1'b1; adr = ADDR_W'(a); rq = r; wr = 1'b1;
    step();
    start = 1'b0;
    while (cyc <= busy_end) begin
      outValid = 1'b0;
      dIn = rnd36();
      parIn = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        if (ovc[k] == cyc) begin
          outValid = 1'b1;
          dIn = w_dat[k];
          parIn = (^w_dat[k]) ^ w_bad[k];
        end
      end
      step();
    end
    outValid = 1'b0;
  endtask

  task automatic fill_quad(input int a);
    for (int k = 0; k < 4; k++) begin
      w_dat[k] = rnd36();
      w_dl[k] = 0;
    end
    w_bad = 4'b0000;
    do_write(a, 4'b1111);
  endtask

  initial begin
    int t, a;
    logic [3:0] r;
    reset = 1'b1; start = 1'b0; adr = '0; rq = '0; wr = 1'b0;
    outValid = 1'b0; dIn = '0; parIn = 1'b0;
    step();
    mon_en = 1;
    step();
    reset = 1'b0;

    // Quad 0x100 = A,B,C,D then read from offset 1: expect B,C,D,A
    w_dat[0] = 36'o111111111111; w_dat[1] = 36'o222222222222;
    w_dat[2] = 36'o333333333333; w_dat[3] = 36'o444444444444;
    w_dl[0] = 0; w_dl[1] = 0; w_dl[2] = 0; w_dl[3] = 0; w_bad = 4'b0000;
    do_write('h100, 4'b1111);
    do_read('h101, 4'b1111, 0);

    // Mask with holes; a start raised mid-cycle must be ignored
    fill_quad('h200);
    do_read('h200, 4'b0101, 1);

    // start with an empty mask does nothing
    idle_until_free();
    start = 1'b1; adr = ADDR_W'('h240); rq = 4'b0000; wr = 1'b0;
    step();
    start = 1'b0;
    step();

    // Wrapping write with slow outValid
    w_dat[0] = 36'o123; w_dat[1] = 36'o456;
    w_dl[0] = 3; w_dl[1] = 3; w_dl[2] = 0; w_dl[3] = 0; w_bad = 4'b0000;
    do_write('h303, 4'b0011);
    do_read('h303, 4'b0011, 0);

    // Bad parity on word 0 is flagged but still stored
    for (int k = 0; k < 4; k++) begin w_dat[k] = rnd36(); w_dl[k] = k; end
    w_bad = 4'b0001;
    do_write('h400, 4'b1111);
    do_read('h400, 4'b1111, 0);

    // Timeout on word 1 drops words 1-3; latest legal outValid is accepted
    fill_quad('h410);
    for (int k = 0; k < 4; k++) w_dat[k] = rnd36();
    w_dl[0] = 0; w_dl[1] = TMO; w_dl[2] = 0; w_dl[3] = 0; w_bad = 4'b0000;
    do_write('h410, 4'b1111);
    do_read('h410, 4'b1111, 0);
    for (int k = 0; k < 4; k++) begin w_dat[k] = rnd36(); w_dl[k] = TMO - 1; end
    do_write('h420, 4'b1111);
    do_read('h420, 4'b1111, 0);

    // Nonexistent address
    do_read(DEPTH, 4'b0001, 0);

    // Reset after the second ackn of a read aborts it
    idle_until_free();
    t = cyc;
    ack_q.push_back(t + 1);
    ack_q.push_back(t + 2);
    cur_t = t;
    busy_end = t + 2;
    start = 1'b1; adr = ADDR_W'('h100); rq = 4'b1111; wr = 1'b0;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    do_read('h101, 4'b1111, 0);

    // Randomised traffic over a preloaded region
    for (int q = 0; q < 16; q++) fill_quad('h500 + 4 * q);
    for (int n = 0; n < 40; n++) begin
      a = 'h500 + int'($urandom_range(0, 63));
      r = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) begin
          w_dat[k] = rnd36();
          w_dl[k] = ($urandom_range(0, 19) == 0) ? TMO : int'($urandom_range(0, 3));
        end
        w_bad = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
        do_write(a, r);
      end else begin
        do_read(a, r, 1'($urandom_range(0, 1)));
      end
    end

    idle_until_free();
    step();
    step();
    tb_done = 1;
  end

endmodule
